if_fetch_pc_unit: RTL and testbench

- Instruction-fetch PC register and IF/ID pipeline latch for the pipelined LEGv8 core.
- Holds the current PC, which drives instruction memory and the A operand of the PC+4 adder.
- Consumes the adder's 64-bit sum as the sequential next PC and redirects to branch targets resolved downstream.
- Handles hazard-unit stalls, branch flushes and a fetch-halt state, and presents {pc, instr, valid} to the ID stage.

---
 rtl/if_fetch_pc_unit.sv | 133 +++++++++++++
 tb/tb_if_fetch_pc_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_pc_unit.sv
// Fetch PC register plus IF/ID latch with RUN/HALTED control for the LEGv8 pipeline.
// Optional FETCH_PERF_CNT_EN adds saturating stall-cycle and redirect counters.
module if_fetch_pc_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] pc,
    input  logic [63:0] pc_plus4,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        take_branch,
    input  logic [63:0] branch_target,
    input  logic        halt_req,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count
`endif
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        misalign_q, misalign_d;
    logic        redirect;
    logic        stall_path;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        misalign_d    = misalign_q;
        redirect      = 1'b0;
        stall_path    = 1'b0;

        // A redirect is accepted in either state and always leaves a bubble behind it.
        if (take_branch) begin
            redirect      = 1'b1;
            state_d       = RUN;
            pc_d          = {branch_target[63:2], 2'b00};
            if_id_pc_d    = 64'h0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            if (branch_target[1:0] != 2'b00)
                misalign_d = 1'b1;
        end else if (state_q == HALTED) begin
            if_id_pc_d    = 64'h0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (halt_req) begin
            state_d       = HALTED;
            if_id_pc_d    = 64'h0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            stall_path = 1'b1;
        end else begin
            pc_d          = pc_plus4;
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_instr;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_valid  = if_id_valid_q;
    assign halted       = (state_q == HALTED);
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        stall_cycles_d   = stall_path ? sat_inc(stall_cycles_q) : stall_cycles_q;
        redirect_count_d = redirect ? sat_inc(redirect_count_q) : redirect_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q   <= 32'h0;
            redirect_count_q <= 32'h0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;
`else
    logic unused_ok;
    assign unused_ok = redirect ^ stall_path;
`endif

endmodule

// File: tb/tb_if_fetch_pc_unit.sv
// Directed bench for if_fetch_pc_unit: a scoreboard queue of hand-written expectations per edge.
module tb_if_fetch_pc_unit;

    localparam logic [63:0] RPC = 64'h100;
    localparam logic [31:0] NOP = 32'hD503_201F;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc, pc_plus4, branch_target, if_id_pc;
    logic [31:0] imem_instr, if_id_instr;
    logic        stall, take_branch, halt_req, if_id_valid, halted, misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, redirect_count;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [31:0] instr;
        logic        vld;
        logic        hlt;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign pc_plus4   = pc + 64'd4;
    assign imem_instr = imem(pc);

    if_fetch_pc_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_plus4(pc_plus4), .imem_instr(imem_instr),
        .stall(stall), .take_branch(take_branch), .branch_target(branch_target),
        .halt_req(halt_req), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .halted(halted), .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".pc"}, pc, e.pc);
        chk({tag, ".if_id_pc"}, if_id_pc, e.ipc);
        chk({tag, ".if_id_instr"}, {32'h0, if_id_instr}, {32'h0, e.instr});
        chk({tag, ".if_id_valid"}, {63'h0, if_id_valid}, {63'h0, e.vld});
        chk({tag, ".halted"}, {63'h0, halted}, {63'h0, e.hlt});
        chk({tag, ".misalign_err"}, {63'h0, misalign_err}, {63'h0, e.mis});
    endtask

    // Drive one cycle of inputs, queue what should appear after the edge, then compare.
    task automatic cyc(input string tag, input logic s, input logic b, input logic [63:0] t,
                       input logic h, input logic [63:0] epc, input logic [63:0] eipc,
                       input logic [31:0] ein, input logic ev, input logic eh, input logic em);
        exp_t e;
        stall = s; take_branch = b; branch_target = t; halt_req = h;
        e.pc = epc; e.ipc = eipc; e.instr = ein; e.vld = ev; e.hlt = eh; e.mis = em;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk_all(tag, sb.pop_front());
        stall = 1'b0; take_branch = 1'b0; halt_req = 1'b0; branch_target = 64'h0;
    endtask

    task automatic async_reset_check(input string tag);
        exp_t e;
        #2 reset = 1'b1;
        #1;
        e.pc = RPC; e.ipc = 64'h0; e.instr = NOP; e.vld = 1'b0; e.hlt = 1'b0; e.mis = 1'b0;
        sb.push_back(e);
        chk_all(tag, sb.pop_front());
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".stall_cycles"}, {32'h0, stall_cycles}, 64'h0);
        chk({tag, ".redirect_count"}, {32'h0, redirect_count}, 64'h0);
`endif
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; take_branch = 1'b0; halt_req = 1'b0; branch_target = 64'h0;
        @(posedge clk); #1;
        cyc("rst_hold", 1'b0, 1'b0, 64'h0, 1'b0, RPC, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rst.pc", pc, RPC);
        chk("rst.valid", {63'h0, if_id_valid}, 64'h0);

        // Sequential fetch from the reset PC
        cyc("seq1", 0, 0, 0, 0, 64'h104, 64'h100, imem(64'h100), 1, 0, 0);
        cyc("seq2", 0, 0, 0, 0, 64'h108, 64'h104, imem(64'h104), 1, 0, 0);
        cyc("stall1", 1, 0, 0, 0, 64'h108, 64'h104, imem(64'h104), 1, 0, 0);
        cyc("stall2", 1, 0, 0, 0, 64'h108, 64'h104, imem(64'h104), 1, 0, 0);
        cyc("release", 0, 0, 0, 0, 64'h10C, 64'h108, imem(64'h108), 1, 0, 0);

        // Branch overrides simultaneous stall; one bubble then target instruction
        cyc("br_stall", 1, 1, 64'h400, 0, 64'h400, 64'h0, NOP, 0, 0, 0);
        cyc("br_tgt", 0, 0, 0, 0, 64'h404, 64'h400, imem(64'h400), 1, 0, 0);

        // Misaligned redirect: aligned pc, sticky flag
        cyc("mis_br", 0, 1, 64'h203, 0, 64'h200, 64'h0, NOP, 0, 0, 1);
        for (int k = 1; k <= 10; k++)
            cyc("mis_run", 0, 0, 0, 0, 64'h200 + 64'(4 * k), 64'h200 + 64'(4 * (k - 1)),
                imem(64'h200 + 64'(4 * (k - 1))), 1, 0, 1);
        async_reset_check("rst_mis");

        // Back-to-back branches: last wins, bubbles throughout
        cyc("bb1", 0, 1, 64'h700, 0, 64'h700, 64'h0, NOP, 0, 0, 0);
        cyc("bb2", 0, 1, 64'h800, 0, 64'h800, 64'h0, NOP, 0, 0, 0);

        // Halt: entered from a valid IF/ID, stall/halt_req ignored, branch exits
        cyc("pre_halt_br", 0, 1, 64'h4FC, 0, 64'h4FC, 64'h0, NOP, 0, 0, 0);
        cyc("pre_halt", 0, 0, 0, 0, 64'h500, 64'h4FC, imem(64'h4FC), 1, 0, 0);
        cyc("halt", 0, 0, 0, 1, 64'h500, 64'h0, NOP, 0, 1, 0);
        cyc("halt_stall", 1, 0, 0, 0, 64'h500, 64'h0, NOP, 0, 1, 0);
        cyc("halt_req2", 0, 0, 0, 1, 64'h500, 64'h0, NOP, 0, 1, 0);
        cyc("halt_idle", 0, 0, 0, 0, 64'h500, 64'h0, NOP, 0, 1, 0);
        cyc("halt_exit", 1, 1, 64'h600, 1, 64'h600, 64'h0, NOP, 0, 0, 0);
        cyc("post_halt", 0, 0, 0, 0, 64'h604, 64'h600, imem(64'h600), 1, 0, 0);

        // Halt beats stall in RUN
        cyc("halt_vs_stall", 1, 0, 0, 1, 64'h604, 64'h0, NOP, 0, 1, 0);
        cyc("halt_mis_exit", 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 0, 0, 1);

        // Adder wrap is taken verbatim
        cyc("wrap", 0, 0, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, imem(64'hFFFF_FFFF_FFFF_FFFC), 1, 0, 1);
        cyc("after_wrap", 0, 0, 0, 0, 64'h4, 64'h0, imem(64'h0), 1, 0, 1);

        // Reset while halted and stalled
        cyc("halt_again", 0, 0, 0, 1, 64'h4, 64'h0, NOP, 0, 1, 1);
        stall = 1'b1;
        async_reset_check("rst_halted");
        stall = 1'b0;
        cyc("post_rst", 0, 0, 0, 0, RPC + 64'd4, RPC, imem(RPC), 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
